// File: rtl/fxp2float_rne_pipe.sv
// Three-stage fixed-point to IEEE-754-style float converter with round-to-nearest-even,
// overflow-to-infinity, flush-to-zero underflow and ready/valid flow control.
module fxp2float_rne_pipe #(
    parameter int unsigned N      = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned SIGNED = 1,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MAN_W  = 23
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           fxp_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   fp_out,
    output logic [2:0]             flags_out
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned XW = EXP_W + 9;
    localparam int unsigned FW = EXP_W + MAN_W + 1;
    localparam int unsigned RW = N + MAN_W + 1;
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

    logic                   s1_valid, s1_sign;
    logic [N-1:0]           s1_mag;
    logic                   s2_valid, s2_sign, s2_zero;
    logic [N-2:0]           s2_frac;
    logic signed [XW-1:0]   s2_exp;
    logic                   adv3, adv2;

    // A stage moves when it is empty or its successor moves
    assign adv3     = !out_valid || out_ready;
    assign adv2     = !s2_valid || adv3;
    assign in_ready = !s1_valid || adv2;

    // S1: sign and magnitude; the most negative input maps to 2^(N-1) without wrapping
    logic         sign_c;
    logic [N-1:0] mag_c;
    always_comb begin
        sign_c = (SIGNED != 0) ? fxp_in[N-1] : 1'b0;
        mag_c  = sign_c ? (~fxp_in + N'(1)) : fxp_in;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= sign_c;
                s1_mag  <= mag_c;
            end
        end
    end

    // S2: leading-one detect; keep only the bits below the implicit one
    logic [PW-1:0]        msb_c;
    logic [N-2:0]         frac_c;
    logic signed [XW-1:0] exp_c;
    always_comb begin
        msb_c = '0;
        for (int i = 0; i < N; i++) begin
            if (s1_mag[i]) msb_c = PW'(i);
        end
        frac_c = (N-1)'(s1_mag << (PW'(N - 1) - msb_c));
        exp_c  = $signed(XW'(msb_c)) - $signed(XW'(FRAC));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_frac  <= '0;
            s2_exp   <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_zero <= (s1_mag == '0);
                s2_frac <= frac_c;
                s2_exp  <= exp_c;
            end
        end
    end

    // S3: round to nearest even, then pack with range handling
    logic [RW-1:0]        ext_c;
    logic [MAN_W-1:0]     man_c;
    logic                 g_c, s_c, up_c;
    logic [MAN_W:0]       man_r_c;
    logic signed [XW-1:0] bexp_c;
    logic [FW-1:0]        fp_c;
    logic [2:0]           flags_c;
    always_comb begin
        ext_c   = {s2_frac, {(MAN_W + 2){1'b0}}};
        man_c   = ext_c[RW-1 -: MAN_W];
        g_c     = ext_c[N];
        s_c     = |ext_c[N-1:0];
        up_c    = g_c & (s_c | man_c[0]);
        man_r_c = {1'b0, man_c} + (MAN_W + 1)'(up_c);
        bexp_c  = s2_exp + BIAS + $signed({{(XW - 1){1'b0}}, man_r_c[MAN_W]});
        fp_c    = '0;
        flags_c = '0;
        if (s2_zero) begin
            fp_c    = '0;
            flags_c = '0;
        end else if (bexp_c >= EMAX) begin
            fp_c    = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c = 3'b101;
        end else if (bexp_c[XW-1] || (bexp_c == '0)) begin
            fp_c    = {s2_sign, {(FW - 1){1'b0}}};
            flags_c = 3'b011;
        end else begin
            fp_c    = {s2_sign, bexp_c[EXP_W-1:0], man_r_c[MAN_W-1:0]};
            flags_c = {2'b00, g_c | s_c};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            fp_out    <= '0;
            flags_out <= '0;
        end else if (adv3) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                fp_out    <= fp_c;
                flags_out <= flags_c;
            end
        end
    end

endmodule

// File: tb/tb_fxp2float_rne_pipe.sv
// Bench for fxp2float_rne_pipe: four parameterisations against an arithmetic reference model.
module tb_fxp2float_rne_pipe;

    typedef struct packed {
        logic [1:0]  k;
        logic [31:0] x;
        logic [31:0] fp;
        logic [2:0]  fl;
    } vec_t;

    typedef struct {
        logic [31:0] fp;
        logic [2:0]  fl;
        int          stamp;
    } exp_t;

    localparam int NV = 15;
    vec_t vecs [NV] = '{
        '{2'd0, 32'h0000_0100, 32'h3F80_0000, 3'b000},
        '{2'd0, 32'h0000_FC80, 32'hC060_0000, 3'b000},
        '{2'd0, 32'h0000_0000, 32'h0000_0000, 3'b000},
        '{2'd0, 32'h0000_8000, 32'hC300_0000, 3'b000},
        '{2'd0, 32'h0000_02C1, 32'h4030_4000, 3'b000},
        '{2'd0, 32'h0000_0001, 32'h3B80_0000, 3'b000},
        '{2'd0, 32'h0000_7FFF, 32'h42FF_FE00, 3'b000},
        '{2'd1, 32'h0000_0801, 32'h0000_6800, 3'b001},
        '{2'd1, 32'h0000_0803, 32'h0000_6802, 3'b001},
        '{2'd1, 32'h0000_7FFF, 32'h0000_7800, 3'b001},
        '{2'd2, 32'h0001_0000, 32'h0000_7C00, 3'b101},
        '{2'd2, 32'hFFFF_0000, 32'h0000_FC00, 3'b101},
        '{2'd2, 32'h0000_FFE0, 32'h0000_7BFF, 3'b000},
        '{2'd3, 32'h0000_0001, 32'h0000_0000, 3'b011},
        '{2'd3, 32'hFFFF_FFFF, 32'h0000_8000, 3'b011}
    };

    logic        clk;
    logic        rstn;
    logic [3:0]  in_valid, out_ready;
    logic [15:0] x_a, x_b;
    logic [31:0] x_c, x_d;
    logic        rdy_a, rdy_b, rdy_c, rdy_d;
    logic        ov_a, ov_b, ov_c, ov_d;
    logic [31:0] fp_a;
    logic [15:0] fp_b, fp_c, fp_d;
    logic [2:0]  fl_a, fl_b, fl_c, fl_d;
    logic [3:0]  in_ready, out_valid;
    logic [3:0][31:0] fpo;
    logic [3:0][2:0]  flo;

    assign in_ready  = {rdy_d, rdy_c, rdy_b, rdy_a};
    assign out_valid = {ov_d, ov_c, ov_b, ov_a};
    assign fpo = {{16'h0, fp_d}, {16'h0, fp_c}, {16'h0, fp_b}, fp_a};
    assign flo = {fl_d, fl_c, fl_b, fl_a};

    fxp2float_rne_pipe #(.N(16), .FRAC(8), .SIGNED(1), .EXP_W(8), .MAN_W(23)) u_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid[0]), .in_ready(rdy_a), .fxp_in(x_a),
        .out_valid(ov_a), .out_ready(out_ready[0]), .fp_out(fp_a), .flags_out(fl_a));
    fxp2float_rne_pipe #(.N(16), .FRAC(0), .SIGNED(1), .EXP_W(5), .MAN_W(10)) u_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid[1]), .in_ready(rdy_b), .fxp_in(x_b),
        .out_valid(ov_b), .out_ready(out_ready[1]), .fp_out(fp_b), .flags_out(fl_b));
    fxp2float_rne_pipe #(.N(32), .FRAC(0), .SIGNED(1), .EXP_W(5), .MAN_W(10)) u_c (
        .clk(clk), .rstn(rstn), .in_valid(in_valid[2]), .in_ready(rdy_c), .fxp_in(x_c),
        .out_valid(ov_c), .out_ready(out_ready[2]), .fp_out(fp_c), .flags_out(fl_c));
    fxp2float_rne_pipe #(.N(32), .FRAC(31), .SIGNED(1), .EXP_W(5), .MAN_W(10)) u_d (
        .clk(clk), .rstn(rstn), .in_valid(in_valid[3]), .in_ready(rdy_d), .fxp_in(x_d),
        .out_valid(ov_d), .out_ready(out_ready[3]), .fp_out(fp_d), .flags_out(fl_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   acc_cnt [4] = '{0, 0, 0, 0};
    logic [3:0] lat_chk = '0;
    logic [3:0] gap_chk = '0;
    exp_t sbq [4][$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: exact integer value, ideal rounding of the quotient, then range checks
    function automatic logic [34:0] model(input int k, input logic [31:0] x);
        int n, frac, ew, mw, p, e_b;
        logic [63:0] raw, mag, q, rem, half;
        logic sgn, inex;
        logic [31:0] fp;
        logic [2:0] fl;
        case (k)
            0:       begin n = 16; frac = 8;  ew = 8; mw = 23; end
            1:       begin n = 16; frac = 0;  ew = 5; mw = 10; end
            2:       begin n = 32; frac = 0;  ew = 5; mw = 10; end
            default: begin n = 32; frac = 31; ew = 5; mw = 10; end
        endcase
        raw = 64'(x) & ((64'd1 << n) - 64'd1);
        sgn = raw[n-1];
        mag = sgn ? ((64'd1 << n) - raw) : raw;
        if (mag == 64'd0) return 35'd0;
        p = 0;
        while ((mag >> (p + 1)) != 64'd0) p++;
        inex = 1'b0;
        if (p <= mw) begin
            q = mag << (mw - p);
        end else begin
            q    = mag >> (p - mw);
            rem  = mag - (q << (p - mw));
            half = 64'd1 << (p - mw - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            inex = (rem != 64'd0);
            if (q == (64'd1 << (mw + 1))) begin
                q = q >> 1;
                p++;
            end
        end
        e_b = p - frac + (1 << (ew - 1)) - 1;
        fp  = 32'(sgn) << (ew + mw);
        if (e_b >= (1 << ew) - 1) begin
            fp = fp | (32'((1 << ew) - 1) << mw);
            fl = 3'b101;
        end else if (e_b <= 0) begin
            fl = 3'b011;
        end else begin
            fp = fp | (32'(e_b) << mw) | 32'(q - (64'd1 << mw));
            fl = {2'b00, inex};
        end
        return {fl, fp};
    endfunction

    function automatic logic [31:0] xin(input int k);
        case (k)
            0:       return 32'(x_a);
            1:       return 32'(x_b);
            2:       return x_c;
            default: return x_d;
        endcase
    endfunction

    // Scoreboard, latency, stall-stability and gap checks, sampled mid-cycle
    logic [3:0]  prev_stall = '0, prev_xfer = '0;
    logic [31:0] prev_fp [4];
    logic [2:0]  prev_fl [4];
    always @(negedge clk) begin
        exp_t e;
        logic [34:0] r;
        if (!rstn) begin
            prev_stall <= '0;
            prev_xfer  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (prev_stall[k]) begin
                    check($sformatf("stall_valid[%0d]", k), out_valid[k], 1);
                    check($sformatf("stall_fp[%0d]", k), fpo[k], prev_fp[k]);
                    check($sformatf("stall_flags[%0d]", k), flo[k], prev_fl[k]);
                end
                if (gap_chk[k] && prev_xfer[k] && sbq[k].size() > 0)
                    check($sformatf("no_gap[%0d]", k), out_valid[k], 1);
                if (out_valid[k] && out_ready[k]) begin
                    if (sbq[k].size() == 0) begin
                        check($sformatf("spurious_out[%0d]", k), out_valid[k], 0);
                    end else begin
                        e = sbq[k].pop_front();
                        check($sformatf("fp[%0d]", k), fpo[k], e.fp);
                        check($sformatf("flags[%0d]", k), flo[k], e.fl);
                        if (lat_chk[k]) check($sformatf("latency[%0d]", k), cycle - e.stamp, 3);
                    end
                end
                if (in_valid[k] && in_ready[k]) begin
                    r = model(k, xin(k));
                    sbq[k].push_back('{fp: r[31:0], fl: r[34:32], stamp: cycle});
                    acc_cnt[k]++;
                end
                prev_stall[k] <= out_valid[k] & ~out_ready[k];
                prev_xfer[k]  <= out_valid[k] & out_ready[k];
                prev_fp[k]    <= fpo[k];
                prev_fl[k]    <= flo[k];
            end
        end
    end

    task automatic push(input int k, input logic [31:0] x);
        int n = 0;
        case (k)
            0:       x_a = x[15:0];
            1:       x_b = x[15:0];
            2:       x_c = x;
            default: x_d = x;
        endcase
        in_valid[k] = 1'b1;
        @(negedge clk);
        while (!in_ready[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept[%0d]", k), in_ready[k], 1);
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_drain(input int k);
        int n = 0;
        while (sbq[k].size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain[%0d]", k), sbq[k].size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [34:0] r;
        logic [31:0] bp [6] = '{32'h0100, 32'h0280, 32'hFF00, 32'h0001, 32'h7FFF, 32'h8001};
        int base, n;
        rstn = 1'b0;
        in_valid = '0;
        out_ready = '1;
        x_a = '0; x_b = '0; x_c = '0; x_d = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_valid[%0d]", k), out_valid[k], 0);
            check($sformatf("rst_fp[%0d]", k), fpo[k], 0);
            check($sformatf("rst_flags[%0d]", k), flo[k], 0);
        end
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("rst_in_ready[%0d]", k), in_ready[k], 1);

        for (int i = 0; i < NV; i++) begin
            r = model(int'(vecs[i].k), vecs[i].x);
            check($sformatf("model_fp[%0d]", i), r[31:0], vecs[i].fp);
            check($sformatf("model_flags[%0d]", i), r[34:32], vecs[i].fl);
        end

        lat_chk = '1;
        for (int i = 0; i < NV; i++) push(int'(vecs[i].k), vecs[i].x);
        for (int k = 0; k < 4; k++) wait_drain(k);
        lat_chk = '0;

        // Backpressure: six offered, three held, then released
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        base = acc_cnt[0];
        fork
            begin
                for (int i = 0; i < 6; i++) push(0, bp[i]);
            end
        join_none
        repeat (10) @(posedge clk);
        #1;
        check("bp_accepted", acc_cnt[0] - base, 3);
        check("bp_in_ready", in_ready[0], 0);
        check("bp_out_valid", out_valid[0], 1);
        gap_chk[0] = 1'b1;
        out_ready[0] = 1'b1;
        n = 0;
        while (acc_cnt[0] - base < 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        wait_drain(0);
        check("bp_total", acc_cnt[0] - base, 6);
        gap_chk[0] = 1'b0;

        // Reset with two samples in flight
        @(posedge clk);
        #1;
        push(0, 32'h0300);
        push(0, 32'h0400);
        @(posedge clk);
        #1;
        check("pre_reset_valid", out_valid[0], 1);
        #1 rstn = 1'b0;
        #1;
        check("mid_reset_valid", out_valid[0], 0);
        check("mid_reset_fp", fpo[0], 0);
        check("mid_reset_flags", flo[0], 0);
        for (int k = 0; k < 4; k++) sbq[k].delete();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_stale", out_valid[0], 0);
        end
        @(posedge clk);
        #1;
        lat_chk[0] = 1'b1;
        base = acc_cnt[0];
        push(0, 32'h0100);
        wait_drain(0);
        check("post_reset_count", acc_cnt[0] - base, 1);
        lat_chk = '0;

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
